// File: rtl/exec_pkg.sv
// Shared constants for the fetch/execute controller: opcodes, FSM states, widths.
package exec_pkg;

  localparam int INST_CAP_DEF  = 20;
  localparam int DATA_LEN_DEF  = 8;
  localparam int FETCH_LAT_DEF = 3;
  localparam int NREGS_DEF     = 8;

  function automatic int pc_width(input int cap);
    return $clog2(cap) + 1;
  endfunction

  localparam int PC_W = pc_width(INST_CAP_DEF);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_XORI = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_RSVD = 4'hD;
  localparam logic [3:0] OP_RSVE = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational accumulator ALU; for LD the caller supplies the register value as d.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic [3:0]          op,
  input  logic [DATA_LEN-1:0] acc,
  input  logic [DATA_LEN-1:0] d,
  input  logic                c,
  output logic [DATA_LEN-1:0] result,
  output logic                c_next,
  output logic                z_next,
  output logic                wr_acc
);

  logic [DATA_LEN:0] wide;

  always_comb begin
    result = acc;
    c_next = c;
    wr_acc = 1'b1;
    wide   = '0;
    case (op)
      OP_LDI:  result = d;
      OP_ADDI: begin
        wide   = {1'b0, acc} + {1'b0, d};
        result = wide[DATA_LEN-1:0];
        c_next = wide[DATA_LEN];
      end
      // The extra top bit of a widened subtract is the borrow.
      OP_SUBI: begin
        wide   = {1'b0, acc} - {1'b0, d};
        result = wide[DATA_LEN-1:0];
        c_next = wide[DATA_LEN];
      end
      OP_ANDI: result = acc & d;
      OP_ORI:  result = acc | d;
      OP_XORI: result = acc ^ d;
      OP_LD:   result = d;
      default: wr_acc = 1'b0;
    endcase
    z_next = (result == '0);
  end

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Fetch/execute sequencer: accumulator machine driving fetch/decode and a byte port.
// Optional macro EXEC_SINGLE_STEP_EN adds a step input for one-instruction-per-edge runs.
module fetch_exec_ctrl
  import exec_pkg::*;
#(
  parameter int INST_CAP  = INST_CAP_DEF,
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int FETCH_LAT = FETCH_LAT_DEF,
  parameter int NREGS     = NREGS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef EXEC_SINGLE_STEP_EN
  input  logic                          step,
`endif
  input  logic [3:0]                    ctrl_bus,
  input  logic [DATA_LEN-1:0]           data_in,
  output logic                          fetch_en,
  output logic [pc_width(INST_CAP)-1:0] pc,
  output logic [DATA_LEN-1:0]           acc,
  output logic [DATA_LEN-1:0]           out_data,
  output logic                          out_valid,
  output logic                          halted,
  output logic                          err
);

  localparam int PCW   = pc_width(INST_CAP);
  localparam int CNT_W = $clog2(FETCH_LAT) + 1;
  localparam int RAW   = $clog2(NREGS);

  // Handshake: fetch_en is a one-cycle request with pc stable until EXEC;
  // ctrl_bus/data_in are sampled only in EXEC. out_valid qualifies out_data
  // for exactly one cycle, with no back-pressure.
  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt;
  logic                 z_flag, c_flag;
  logic [DATA_LEN-1:0]  regs [NREGS];
  logic                 launch;

  logic [RAW-1:0]       reg_addr;
  logic [DATA_LEN-1:0]  operand;
  logic [DATA_LEN-1:0]  alu_result;
  logic                 alu_c, alu_z, alu_wr;
  logic                 taken, jump_bad, illegal, stop_exec;
  logic [PCW-1:0]       pc_seq;

  assign reg_addr  = data_in[RAW-1:0];
  assign operand   = (ctrl_bus == OP_LD) ? regs[reg_addr] : data_in;
  assign taken     = (ctrl_bus == OP_JMP) || (ctrl_bus == OP_JZ && z_flag) ||
                     (ctrl_bus == OP_JC && c_flag);
  assign jump_bad  = taken && (32'(data_in) >= 32'(INST_CAP));
  assign illegal   = (ctrl_bus == OP_RSVD) || (ctrl_bus == OP_RSVE);
  assign stop_exec = illegal || jump_bad || (ctrl_bus == OP_HLT);
  assign pc_seq    = (pc == PCW'(INST_CAP - 1)) ? '0 : pc + PCW'(1);

  exec_alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .op     (ctrl_bus),
    .acc    (acc),
    .d      (operand),
    .c      (c_flag),
    .result (alu_result),
    .c_next (alu_c),
    .z_next (alu_z),
    .wr_acc (alu_wr)
  );

`ifdef EXEC_SINGLE_STEP_EN
  logic step_q, launched;
  // start only launches the first instruction; afterwards each step rise does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= 1'b0;
      launched <= 1'b0;
    end else begin
      step_q <= step;
      if (state == S_IDLE && state_d == S_REQ) launched <= 1'b1;
    end
  end
  assign launch = launched ? (step && !step_q) : start;
`else
  assign launch = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state == S_WAIT) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (launch) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (cnt == CNT_W'(FETCH_LAT - 1)) state_d = S_EXEC;
`ifdef EXEC_SINGLE_STEP_EN
      S_EXEC: state_d = stop_exec ? S_HALT : S_IDLE;
`else
      S_EXEC: state_d = stop_exec ? S_HALT : S_REQ;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_en = (state == S_REQ);
    halted   = (state == S_HALT);
  end

  // Architectural state changes only in a non-halting EXEC, so a halt or
  // fault leaves acc, flags, regs and pc exactly as they were.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      acc       <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_EXEC) begin
        if (illegal || jump_bad) err <= 1'b1;
        if (!stop_exec) begin
          if (alu_wr) begin
            acc    <= alu_result;
            z_flag <= alu_z;
            c_flag <= alu_c;
          end
          if (ctrl_bus == OP_ST) regs[reg_addr] <= acc;
          if (ctrl_bus == OP_OUT) begin
            out_data  <= acc;
            out_valid <= 1'b1;
          end
          pc <= taken ? PCW'(data_in) : pc_seq;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: a fetch/decode model with latency feeds
// small programs; a monitor checks fetch addresses, spacing and output bytes.
module tb_fetch_exec_ctrl;
  import exec_pkg::*;

  localparam int FL = FETCH_LAT_DEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start    = 1'b0;
  logic [3:0]      ctrl_bus = 4'hD;
  logic [7:0]      data_in  = 8'hFF;
  logic            fetch_en;
  logic [PC_W-1:0] pc;
  logic [7:0]      acc;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            halted;
  logic            err;
`ifdef EXEC_SINGLE_STEP_EN
  logic            step = 1'b0;
`endif

  fetch_exec_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef EXEC_SINGLE_STEP_EN
    .step      (step),
`endif
    .ctrl_bus  (ctrl_bus),
    .data_in   (data_in),
    .fetch_en  (fetch_en),
    .pc        (pc),
    .acc       (acc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .err       (err)
  );

  // scoreboard state
  logic [7:0]      exp_q[$];
  logic [PC_W-1:0] exp_pc_q[$];
  logic [11:0]     mem [32];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_fe     = -1;
  int fetch_cnt   = 0;
  bit spacing_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // fetch/decode model: garbage (illegal opcode) until FETCH_LAT cycles after the request
  initial begin
    logic [PC_W-1:0] a;
    forever begin
      @(negedge clk);
      if (fetch_en && !rst) begin
        a        = pc;
        ctrl_bus = 4'hD;
        data_in  = 8'hFF;
        repeat (FL) @(posedge clk);
        #1;
        {ctrl_bus, data_in} = mem[a];
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_valid unexpected", 32'(out_valid), 0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (fetch_en) begin
        fetch_cnt++;
        if (exp_pc_q.size() == 0) check("fetch unexpected", 32'(fetch_en), 0);
        else check("fetch pc", 32'(pc), 32'(exp_pc_q.pop_front()));
        if (spacing_chk && last_fe >= 0) check("fetch spacing", 32'(cyc - last_fe), 5);
        last_fe = cyc;
      end
    end
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = {OP_HLT, 8'h00};
  endtask

  task automatic put(input int a, input logic [3:0] op, input logic [7:0] d);
    mem[a] = {op, d};
  endtask

  task automatic exp_pcs(input int n, input int seq[16]);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(PC_W'(seq[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_pc_q.delete();
    last_fe   = -1;
    fetch_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, " halted"}, 32'(halted), 1);
  endtask

  task automatic expect_end(input string name, input logic [7:0] acc_e,
                            input logic [PC_W-1:0] pc_e, input logic err_e);
    repeat (3) @(negedge clk);
    check({name, " acc"}, 32'(acc), 32'(acc_e));
    check({name, " pc"}, 32'(pc), 32'(pc_e));
    check({name, " err"}, 32'(err), 32'(err_e));
    check({name, " fetch_en idle"}, 32'(fetch_en), 0);
    check({name, " outputs left"}, 32'(exp_q.size()), 0);
    check({name, " fetches left"}, 32'(exp_pc_q.size()), 0);
  endtask

  task automatic load_p1();
    clear_mem();
    put(0, OP_LDI, 8'd5);
    put(1, OP_ADDI, 8'd3);
    put(2, OP_OUT, 8'd0);
    put(3, OP_HLT, 8'd0);
  endtask

  task automatic push_p1();
    exp_pcs(4, '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    exp_q.push_back(8'd8);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;

    // P1: LDI 5; ADDI 3; OUT; HLT, plus reset values
    load_p1();
    do_reset();
    @(negedge clk);
    check("reset pc", 32'(pc), 0);
    check("reset acc", 32'(acc), 0);
    check("reset fetch_en", 32'(fetch_en), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset halted", 32'(halted), 0);
    check("reset err", 32'(err), 0);
    repeat (5) @(negedge clk);
    check("idle without start", 32'(fetch_cnt), 0);
    push_p1();
    launch();
    wait_halt("p1");
    expect_end("p1", 8'd8, 3, 1'b0);

    // P2: carry out of ADDI, taken JC
    clear_mem();
    put(0, OP_LDI, 8'd200);
    put(1, OP_ADDI, 8'd100);
    put(2, OP_JC, 8'd6);
    put(6, OP_OUT, 8'd0);
    put(7, OP_HLT, 8'd0);
    do_reset();
    exp_pcs(5, '{0, 1, 2, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    exp_q.push_back(8'd44);
    launch();
    wait_halt("p2");
    expect_end("p2", 8'd44, 7, 1'b0);

    // P3: SUBI to zero, taken JZ to HLT
    clear_mem();
    put(0, OP_LDI, 8'd3);
    put(1, OP_SUBI, 8'd3);
    put(2, OP_JZ, 8'd9);
    put(3, OP_OUT, 8'd0);
    put(9, OP_HLT, 8'd0);
    do_reset();
    exp_pcs(4, '{0, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    launch();
    wait_halt("p3");
    expect_end("p3", 8'd0, 9, 1'b0);

    // P4: jump beyond INST_CAP
    clear_mem();
    put(0, OP_LDI, 8'd7);
    put(1, OP_JMP, 8'd25);
    do_reset();
    exp_pcs(2, '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    launch();
    wait_halt("p4");
    expect_end("p4", 8'd7, 1, 1'b1);

    // P5: logic ops, ST/LD with address wrap, borrow, NOP, illegal opcode E
    clear_mem();
    put(0, OP_LDI, 8'h5A);
    put(1, OP_ST, 8'd10);
    put(2, OP_LDI, 8'h01);
    put(3, OP_XORI, 8'hFF);
    put(4, OP_OUT, 8'h00);
    put(5, OP_LD, 8'd2);
    put(6, OP_ANDI, 8'h0F);
    put(7, OP_ORI, 8'h30);
    put(8, OP_OUT, 8'h00);
    put(9, OP_SUBI, 8'h3B);
    put(10, OP_JC, 8'd12);
    put(12, OP_OUT, 8'h00);
    put(13, OP_NOP, 8'h00);
    put(14, OP_RSVE, 8'h00);
    do_reset();
    exp_pcs(14, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14, 0, 0});
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'hFF);
    launch();
    wait_halt("p5");
    expect_end("p5", 8'hFF, 14, 1'b1);

    // P6: JZ not taken, pc wrap 19 -> 0, then JZ taken
    clear_mem();
    put(0, OP_JZ, 8'd5);
    put(1, OP_JMP, 8'd18);
    put(5, OP_HLT, 8'd0);
    put(18, OP_LDI, 8'd0);
    put(19, OP_OUT, 8'd0);
    do_reset();
    exp_pcs(6, '{0, 1, 18, 19, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    exp_q.push_back(8'd0);
    launch();
    wait_halt("p6");
    expect_end("p6", 8'd0, 5, 1'b0);

`ifndef EXEC_SINGLE_STEP_EN
    // asynchronous reset in WAIT of the third instruction, then a clean rerun
    load_p1();
    do_reset();
    push_p1();
    launch();
    n = 0;
    while (fetch_cnt < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("third fetch reached", 32'(fetch_cnt), 3);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre-reset acc", 32'(acc), 8);
    check("pre-reset pc", 32'(pc), 2);
    rst = 1'b1;
    #1;
    check("async reset acc", 32'(acc), 0);
    check("async reset pc", 32'(pc), 0);
    check("async reset fetch_en", 32'(fetch_en), 0);
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset halted", 32'(halted), 0);
    do_reset();
    push_p1();
    launch();
    wait_halt("rerun");
    expect_end("rerun", 8'd8, 3, 1'b0);
`else
    // single-step: start launches one instruction, each step rise one more
    spacing_chk = 1'b0;
    load_p1();
    do_reset();
    push_p1();
    launch();
    repeat (30) @(negedge clk);
    check("step after start fetches", 32'(fetch_cnt), 1);
    check("step after start acc", 32'(acc), 5);
    step = 1'b1;
    repeat (30) @(negedge clk);
    check("step held fetches", 32'(fetch_cnt), 2);
    check("step held acc", 32'(acc), 8);
    step = 1'b0;
    repeat (5) @(negedge clk);
    step = 1'b1;
    repeat (30) @(negedge clk);
    check("step 2 fetches", 32'(fetch_cnt), 3);
    check("step 2 halted", 32'(halted), 0);
    step = 1'b0;
    repeat (5) @(negedge clk);
    step = 1'b1;
    repeat (30) @(negedge clk);
    step = 1'b0;
    check("step 3 fetches", 32'(fetch_cnt), 4);
    wait_halt("step");
    expect_end("step", 8'd8, 3, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
- Consumer end of the fetch/decode interface: drives `pc` and the fetch enable, then samples the returned 4-bit control bus and 8-bit data field and executes it.
- Accumulator machine with a small scratch register file and a byte output port.
- Sits between the fetch/decode unit and system I/O; owns program sequencing: PC increment, jumps, halt.

Parameters:
- INST_CAP, 20: instruction memory depth; legal PC range 0..INST_CAP-1.
- DATA_LEN, 8: accumulator/data width.
- FETCH_LAT, 3: cycles from the fetch-enable cycle until control/data are stable.
- NREGS, 8: scratch registers, addressed by data[$clog2(NREGS)-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; starts or resumes execution from IDLE.
- ctrl_bus  in  4  opcode from fetch/decode.
- data_in  in  DATA_LEN  immediate/operand from fetch/decode.
- fetch_en  out  1  one-cycle fetch request to fetch/decode.
- pc  out  $clog2(INST_CAP)+1  instruction address.
- acc  out  DATA_LEN  accumulator.
- out_data  out  DATA_LEN  output port.
- out_valid  out  1  one-cycle strobe with out_data.
- halted  out  1  high in HALT.
- err  out  1  sticky error: illegal opcode or bad jump target.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, pc=0, acc=0, Z=0, C=0, all regs=0, fetch_en=0, out_data=0, out_valid=0, halted=0, err=0. Reset mid-instruction abandons the instruction; no partial writes.
- States:
  - IDLE: wait for start=1, then go to REQ.
  - REQ: fetch_en=1 for exactly one cycle, then go to WAIT with cnt=0.
  - WAIT: cnt increments each cycle; when cnt==FETCH_LAT-1, go to EXEC.
  - EXEC: sample ctrl_bus/data_in, execute, update pc; go to REQ, or HALT on halt/error.
  - HALT: stays until reset.
- Throughput: one instruction per FETCH_LAT+2 cycles (5 at default).
- pc holds constant from REQ through WAIT.
- Opcodes (d = data_in):
  - 0 NOP.
  - 1 LDI: acc=d.
  - 2 ADDI: {C,acc}=acc+d.
  - 3 SUBI: {C,acc}=acc-d; C=borrow.
  - 4 ANDI, 5 ORI, 6 XORI: acc=acc op d; C unchanged.
  - 7 JMP: pc=d.
  - 8 JZ: if Z then pc=d.
  - 9 JC: if C then pc=d.
  - A ST: reg[d]=acc.
  - B LD: acc=reg[d].
  - C OUT: out_data=acc; out_valid=1 for the EXEC+1 cycle only.
  - F HLT.
  - D, E: illegal.
- Z flag: updated (acc_result==0) by ops 1–6 and B; held otherwise.
- Next PC:
  - Taken jump: pc=d. If d>=INST_CAP, set err and go to HALT; pc is unchanged.
  - Otherwise pc+1, wrapping INST_CAP-1 → 0.
- Illegal opcode: err=1, go to HALT; acc, flags and regs are unchanged.
- HLT: halted=1 from the next cycle; fetch_en stays 0.
- start is ignored outside IDLE. Deasserting start mid-program has no effect.
- Register address: the upper bits of d are ignored (modulo NREGS).

Optional Feature:
- Macro: EXEC_SINGLE_STEP_EN.
- With the macro defined:
  - Adds input `step` (1 bit).
  - After each EXEC (non-halting) the FSM returns to IDLE, not REQ.
  - A rising edge of `step` (detected internally) launches exactly one instruction; start then acts only as the initial launch.
- Without the macro: no `step` port; free-running as described above.

Decomposition:
- Shared package `exec_pkg`:
  - Opcode localparams: OP_NOP..OP_HLT.
  - State encodings: S_IDLE, S_REQ, S_WAIT, S_EXEC, S_HALT.
  - Width helper: PC_W=$clog2(INST_CAP)+1.
- One sub-module `exec_alu`: combinational; inputs op, acc, d, C; outputs result, C_next, Z_next, wr_acc.
- The top holds the FSM, PC, register file and output port.

Test Plan:
- LDI 5; ADDI 3; OUT; HLT, with start pulsed after reset:
  - out_valid pulses once with out_data=8.
  - halted=1.
  - fetch_en pulses at 5-cycle spacing.
  - pc sequence 0,1,2,3.
- LDI 200; ADDI 100; JC 6 (pc6 = OUT):
  - acc=44, C=1.
  - pc jumps to 6; OUT emits 44.
- LDI 3; SUBI 3; JZ 9; at 9: HLT:
  - Z=1, pc=9, halted; no err.
- JMP 25 with INST_CAP=20:
  - err=1, halted=1, pc stays at the JMP address.
- Opcode E:
  - err=1, HALT, acc unchanged.
- Reset asserted during WAIT:
  - All outputs return to reset values immediately (asynchronously).
  - After release and start, execution restarts at pc=0.
- With EXEC_SINGLE_STEP_EN:
  - Exactly one instruction per step edge.
  - fetch_en stays 0 while step is held high.
